imem_access_arbiter: RTL and testbench
======================================

// Module: imem_access_arbiter
// PURPOSE
//  Shares the single-port instruction RAM (1024x32, byte-enabled, address registered in RAM)
//  between two Avalon-MM hosts: CPU instruction fetch (read-only) and the program loader/debug
//  port (read/write). Grants one access per cycle, returns read data tagged to its originator.
//  Sits between the fetch unit/loader and the RAM inside the QSYS subsystem.
// PARAMETERS
//  ADDR_W         10   word address width (RAM depth 2**ADDR_W)
//  DATA_W         32   data width; BE_W = DATA_W/8
//  RD_LATENCY     1    cycles from granted read to valid RAM q (1 = unregistered q, 2 = registered)
//  MAX_FETCH_RUN  4    max consecutive contended fetch grants before loader is served (1..15)
// PORTS
//  clk              in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  hold             in   1       stall: no new grants, RAM clken dropped
//  f_address        in   ADDR_W  fetch word address
//  f_read           in   1       fetch read request
//  f_waitrequest    out  1       fetch request not accepted this cycle
//  f_readdata       out  DATA_W  fetch read data
//  f_readdatavalid  out  1       f_readdata valid
//  l_address        in   ADDR_W  loader word address
//  l_read           in   1       loader read request
//  l_write          in   1       loader write request
//  l_byteenable     in   BE_W    loader byte enables
//  l_writedata      in   DATA_W  loader write data
//  l_waitrequest    out  1       loader request not accepted this cycle
//  l_readdata       out  DATA_W  loader read data
//  l_readdatavalid  out  1       l_readdata valid
//  mem_address      out  ADDR_W  RAM address
//  mem_byteenable   out  BE_W    RAM byte enables (all ones for fetch)
//  mem_chipselect   out  1       RAM select (high on any grant)
//  mem_write        out  1       RAM write enable
//  mem_writedata    out  DATA_W  RAM write data
//  mem_clken        out  1       RAM clock enable = ~hold
//  mem_readdata     in   DATA_W  RAM q
// BEHAVIOUR
//  - Reset: run counter=0, last_grant=FETCH, tag pipe cleared; both readdatavalid=0.
//    While reset high no grant: waitrequest = request. Reset mid-read drops the return.
//  - Grant is combinational from requests+state; mem_* driven combinationally from winner.
//    Accepted access = request & ~waitrequest. Non-winner sees waitrequest=1, must hold inputs.
//  - l_read & l_write both high: treated as write; l_readdatavalid not generated.
//  - Arbitration: only one requester -> it wins. Both: fetch wins unless run counter ==
//    MAX_FETCH_RUN, then loader wins. Counter +1 on each contended fetch grant, cleared on
//    any loader grant or any cycle fetch is not requesting; saturates at MAX_FETCH_RUN.
//  - hold=1: no grants, both waitrequest = request, counter and tags frozen, mem_clken=0.
//  - Reads: tag {valid,id} enters RD_LATENCY-deep shift pipe on grant; at pipe output the
//    matching *_readdatavalid pulses 1 cycle and *_readdata = mem_readdata (both ports
//    see mem_readdata; only valid differs). Pipe advances only when hold=0.
//  - Ordering: accesses execute in grant order; loader write then fetch read of same
//    address in next cycle returns new data (RAM write completes at grant edge).
//  - Throughput: one access/cycle, fully pipelined reads, no bubbles between grants.
//  - No idle output glitches: with no grant mem_chipselect=0, mem_write=0.
// STRUCTURE
//  - imem_arb_pkg: PORT_FETCH/PORT_LOADER id constants, tag struct {valid,id},
//    default ADDR_W/DATA_W.
//  - Sub-module imem_rd_tag_pipe: RD_LATENCY-stage tag shift register with enable.
//  - Top: grant logic, run counter, mem-side muxes, return demux.
// TESTING
//  1. Reset then f_read addr 0x005 alone -> granted same cycle, f_readdatavalid 1 cycle later
//     (RD_LATENCY=1) with RAM word 0x005; l_readdatavalid stays 0.
//  2. Loader write 0x3FF, be=4'b0011, data 0xDEADBEEF over 0x12345678, then fetch read 0x3FF
//     -> f_readdata 0x1234BEEF.
//  3. Both request continuously, MAX_FETCH_RUN=4 -> grant pattern F,F,F,F,L repeating;
//     loader never waits >4 cycles.
//  4. hold asserted mid fetch stream for 3 cycles -> no grants, mem_clken=0, pending
//     readdatavalid delayed by 3 cycles, data unchanged.
//  5. Reset asserted async one cycle after a loader read grant -> l_readdatavalid never
//     pulses, counter 0, first post-reset contended grant goes to fetch.
//  6. RD_LATENCY=2 back-to-back alternating F/L reads -> valids return in order, 2 cycles
//     after each grant, routed to correct port.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared constants and types for the instruction-RAM access arbiter.
// The tag follows each granted read through the latency pipe back to its port.
package imem_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   localparam logic PORT_FETCH  = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

endpackage

// File: rtl/imem_rd_tag_pipe.sv
// Delay line that carries read tags for DEPTH cycles.
// It advances only when en is high, so it stays in step with a clock-enabled RAM.
module imem_rd_tag_pipe
   import imem_arb_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stage_q [DEPTH];
   tag_t stage_d [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_comb begin
               stage_d[gi] = stage_q[gi];
               if (en) stage_d[gi] = tag_in;
            end
         end else begin : g_body
            always_comb begin
               stage_d[gi] = stage_q[gi];
               if (en) stage_d[gi] = stage_q[gi-1];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) stage_q[gi] <= '0;
            else       stage_q[gi] <= stage_d[gi];
         end
      end
   endgenerate

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/imem_access_arbiter.sv
// Lets the instruction-fetch port and the loader/debug port share one single-port RAM.
// Fetch has priority, but only for a bounded run of contended cycles.
module imem_access_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int RD_LATENCY    = 1,
   parameter int MAX_FETCH_RUN = 4
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                hold,
   input  logic [ADDR_W-1:0]   f_address,
   input  logic                f_read,
   output logic                f_waitrequest,
   output logic [DATA_W-1:0]   f_readdata,
   output logic                f_readdatavalid,
   input  logic [ADDR_W-1:0]   l_address,
   input  logic                l_read,
   input  logic                l_write,
   input  logic [DATA_W/8-1:0] l_byteenable,
   input  logic [DATA_W-1:0]   l_writedata,
   output logic                l_waitrequest,
   output logic [DATA_W-1:0]   l_readdata,
   output logic                l_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int         BE_W    = DATA_W / 8;
   localparam logic [3:0] RUN_MAX = 4'(MAX_FETCH_RUN);

   logic [3:0] run_q, run_d;
   logic       f_req, l_req;
   logic       grant_f, grant_l;
   tag_t       tag_in, tag_out;

   assign f_req = f_read;
   assign l_req = l_read | l_write;

   always_comb begin
      grant_f = 1'b0;
      grant_l = 1'b0;
      if (!reset && !hold) begin
         if (f_req && l_req) begin
            if (run_q == RUN_MAX) grant_l = 1'b1;
            else                  grant_f = 1'b1;
         end else begin
            grant_f = f_req;
            grant_l = l_req;
         end
      end
   end

   // An uncontended fetch grant neither extends nor breaks the run.
   always_comb begin
      run_d = run_q;
      if (!hold) begin
         if (grant_l || !f_req)
            run_d = '0;
         else if (grant_f && l_req && run_q != RUN_MAX)
            run_d = run_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) run_q <= '0;
      else       run_q <= run_d;
   end

   assign f_waitrequest  = f_req & ~grant_f;
   assign l_waitrequest  = l_req & ~grant_l;

   assign mem_address    = grant_l ? l_address : f_address;
   assign mem_byteenable = grant_l ? l_byteenable : {BE_W{1'b1}};
   assign mem_chipselect = grant_f | grant_l;
   assign mem_write      = grant_l & l_write;
   assign mem_writedata  = l_writedata;
   assign mem_clken      = ~hold;

   // Read+write together is a write, so it carries no tag.
   always_comb begin
      tag_in.valid = grant_f | (grant_l & l_read & ~l_write);
      tag_in.id    = grant_l ? PORT_LOADER : PORT_FETCH;
   end

   imem_rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .en      (~hold),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // A tag parked during hold is presented once the pipe moves again.
   assign f_readdatavalid = tag_out.valid & ~hold & (tag_out.id == PORT_FETCH);
   assign l_readdatavalid = tag_out.valid & ~hold & (tag_out.id == PORT_LOADER);
   assign f_readdata      = mem_readdata;
   assign l_readdata      = mem_readdata;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench: instance A (latency 1) and instance B (latency 2), each with a behavioural RAM.
module tb_imem_access_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, ram_init;
   int   n_checks = 0;
   int   n_errors = 0;

   // instance A signals
   logic        hold;
   logic [9:0]  f_address, l_address, mem_address;
   logic        f_read, f_waitrequest, f_readdatavalid;
   logic        l_read, l_write, l_waitrequest, l_readdatavalid;
   logic [3:0]  l_byteenable, mem_byteenable;
   logic [31:0] l_writedata, f_readdata, l_readdata, mem_writedata, a_q;
   logic        mem_chipselect, mem_write, mem_clken;

   // instance B signals
   logic [9:0]  b_f_address, b_l_address, b_mem_address;
   logic        b_f_read, b_f_waitrequest, b_f_readdatavalid;
   logic        b_l_read, b_l_waitrequest, b_l_readdatavalid;
   logic [3:0]  b_mem_byteenable;
   logic [31:0] b_f_readdata, b_l_readdata, b_mem_writedata, b_q1, b_q2;
   logic        b_mem_chipselect, b_mem_write, b_mem_clken;

   imem_access_arbiter #(.RD_LATENCY(1), .MAX_FETCH_RUN(4)) dut_a (
      .clk(clk), .reset(reset), .hold(hold),
      .f_address(f_address), .f_read(f_read), .f_waitrequest(f_waitrequest),
      .f_readdata(f_readdata), .f_readdatavalid(f_readdatavalid),
      .l_address(l_address), .l_read(l_read), .l_write(l_write),
      .l_byteenable(l_byteenable), .l_writedata(l_writedata),
      .l_waitrequest(l_waitrequest), .l_readdata(l_readdata), .l_readdatavalid(l_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(a_q)
   );

   imem_access_arbiter #(.RD_LATENCY(2), .MAX_FETCH_RUN(4)) dut_b (
      .clk(clk), .reset(reset), .hold(1'b0),
      .f_address(b_f_address), .f_read(b_f_read), .f_waitrequest(b_f_waitrequest),
      .f_readdata(b_f_readdata), .f_readdatavalid(b_f_readdatavalid),
      .l_address(b_l_address), .l_read(b_l_read), .l_write(1'b0),
      .l_byteenable(4'hF), .l_writedata(32'h0),
      .l_waitrequest(b_l_waitrequest), .l_readdata(b_l_readdata), .l_readdatavalid(b_l_readdatavalid),
      .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable), .mem_chipselect(b_mem_chipselect),
      .mem_write(b_mem_write), .mem_writedata(b_mem_writedata), .mem_clken(b_mem_clken),
      .mem_readdata(b_q2)
   );

   // RAM models: word i initialised to 0xA0000000|i, address registered, byte-enabled writes.
   logic [31:0] ram_a [1024];
   logic [31:0] ram_b [1024];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram_a[i] <= 32'hA000_0000 | 32'(i);
      end else if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram_a[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            a_q <= ram_a[mem_address];
         end
      end
   end

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram_b[i] <= 32'hA000_0000 | 32'(i);
      end else if (b_mem_clken) begin
         if (b_mem_chipselect && !b_mem_write) b_q1 <= ram_b[b_mem_address];
         b_q2 <= b_q1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a;
      f_read = 1'b0; l_read = 1'b0; l_write = 1'b0; hold = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ram_init = 1'b1; hold = 1'b0;
      f_address = '0; f_read = 1'b0;
      l_address = '0; l_read = 1'b0; l_write = 1'b0; l_byteenable = 4'hF; l_writedata = '0;
      b_f_address = '0; b_f_read = 1'b0; b_l_address = '0; b_l_read = 1'b0;

      // reset: requests are not granted
      tick;
      f_read = 1'b1; l_read = 1'b1;
      #1;
      check("rst_f_wait", 32'(f_waitrequest), 32'd1);
      check("rst_l_wait", 32'(l_waitrequest), 32'd1);
      check("rst_cs", 32'(mem_chipselect), 32'd0);
      check("rst_f_valid", 32'(f_readdatavalid), 32'd0);
      check("rst_l_valid", 32'(l_readdatavalid), 32'd0);
      tick;
      idle_a();
      tick;
      ram_init = 1'b0; reset = 1'b0;
      tick;

      // 1: single fetch read of 0x005
      f_read = 1'b1; f_address = 10'h005;
      #1;
      check("t1_f_wait", 32'(f_waitrequest), 32'd0);
      check("t1_cs", 32'(mem_chipselect), 32'd1);
      check("t1_addr", 32'(mem_address), 32'h005);
      check("t1_be", 32'(mem_byteenable), 32'hF);
      tick;
      idle_a();
      #1;
      check("t1_f_valid", 32'(f_readdatavalid), 32'd1);
      check("t1_f_data", f_readdata, 32'hA000_0005);
      check("t1_l_valid", 32'(l_readdatavalid), 32'd0);
      check("idle_cs", 32'(mem_chipselect), 32'd0);
      check("idle_we", 32'(mem_write), 32'd0);
      tick;
      check("t1_f_valid_end", 32'(f_readdatavalid), 32'd0);

      // 2: byte-enabled loader write then immediate fetch of the same word
      l_write = 1'b1; l_address = 10'h3FF; l_byteenable = 4'hF; l_writedata = 32'h1234_5678;
      #1;
      check("t2_l_wait", 32'(l_waitrequest), 32'd0);
      check("t2_we", 32'(mem_write), 32'd1);
      tick;
      l_byteenable = 4'b0011; l_writedata = 32'hDEAD_BEEF;
      #1;
      check("t2_be", 32'(mem_byteenable), 32'h3);
      tick;
      l_write = 1'b0; f_read = 1'b1; f_address = 10'h3FF;
      tick;
      idle_a();
      #1;
      check("t2_f_valid", 32'(f_readdatavalid), 32'd1);
      check("t2_f_data", f_readdata, 32'h1234_BEEF);
      check("t2_wr_no_valid", 32'(l_readdatavalid), 32'd0);

      // read+write together behaves as a write with no read return
      l_read = 1'b1; l_write = 1'b1; l_address = 10'h010; l_byteenable = 4'hF; l_writedata = 32'h0000_0055;
      #1;
      check("rw_we", 32'(mem_write), 32'd1);
      tick;
      l_write = 1'b0;
      #1;
      check("rw_no_valid", 32'(l_readdatavalid), 32'd0);
      tick;
      idle_a();
      #1;
      check("l_rd_valid", 32'(l_readdatavalid), 32'd1);
      check("l_rd_data", l_readdata, 32'h0000_0055);
      check("l_rd_f_valid", 32'(f_readdatavalid), 32'd0);
      tick;

      // 3: continuous contention -> F,F,F,F,L repeating
      for (int i = 0; i < 10; i++) begin
         f_read = 1'b1; f_address = 10'h060; l_read = 1'b1; l_address = 10'h050;
         #1;
         check($sformatf("t3_l_wait_%0d", i), 32'(l_waitrequest), 32'((i % 5) != 4));
         check($sformatf("t3_f_wait_%0d", i), 32'(f_waitrequest), 32'((i % 5) == 4));
         if (i > 0) begin
            check($sformatf("t3_l_valid_%0d", i), 32'(l_readdatavalid), 32'(((i - 1) % 5) == 4));
            check($sformatf("t3_f_valid_%0d", i), 32'(f_readdatavalid), 32'(((i - 1) % 5) != 4));
         end
         tick;
      end
      idle_a();
      tick;

      // 4: hold for three cycles in the middle of a fetch stream
      f_read = 1'b1; f_address = 10'h020;
      tick;
      f_address = 10'h021; hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t4_hold_valid_%0d", i), 32'(f_readdatavalid), 32'd0);
         check($sformatf("t4_hold_clken_%0d", i), 32'(mem_clken), 32'd0);
         check($sformatf("t4_hold_wait_%0d", i), 32'(f_waitrequest), 32'd1);
         check($sformatf("t4_hold_cs_%0d", i), 32'(mem_chipselect), 32'd0);
         tick;
      end
      hold = 1'b0;
      #1;
      check("t4_rel_valid", 32'(f_readdatavalid), 32'd1);
      check("t4_rel_data", f_readdata, 32'hA000_0020);
      check("t4_rel_wait", 32'(f_waitrequest), 32'd0);
      tick;
      idle_a();
      #1;
      check("t4_next_valid", 32'(f_readdatavalid), 32'd1);
      check("t4_next_data", f_readdata, 32'hA000_0021);
      tick;

      // 5: build a full fetch run, then reset during the loader read grant
      for (int i = 0; i < 4; i++) begin
         f_read = 1'b1; f_address = 10'h070; l_read = 1'b1; l_address = 10'h030;
         tick;
      end
      #1;
      check("t5_l_grant", 32'(l_waitrequest), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_cs", 32'(mem_chipselect), 32'd0);
      tick;
      check("t5_rst_l_valid", 32'(l_readdatavalid), 32'd0);
      tick;
      reset = 1'b0;
      #1;
      check("t5_post_l_valid", 32'(l_readdatavalid), 32'd0);
      check("t5_post_f_wait", 32'(f_waitrequest), 32'd0);
      check("t5_post_l_wait", 32'(l_waitrequest), 32'd1);
      tick;
      idle_a();
      #1;
      check("t5_post_f_valid", 32'(f_readdatavalid), 32'd1);
      check("t5_post_l_valid2", 32'(l_readdatavalid), 32'd0);
      tick;

      // 6: latency-2 instance, alternating fetch/loader reads
      for (int k = 0; k < 6; k++) begin
         b_f_read = (k == 0 || k == 2);
         b_l_read = (k == 1 || k == 3);
         b_f_address = 10'h040 + 10'(k);
         b_l_address = 10'h040 + 10'(k);
         #1;
         if (k < 4) check($sformatf("t6_cs_%0d", k), 32'(b_mem_chipselect), 32'd1);
         if (k >= 2) begin
            check($sformatf("t6_f_valid_%0d", k), 32'(b_f_readdatavalid), 32'(k == 2 || k == 4));
            check($sformatf("t6_l_valid_%0d", k), 32'(b_l_readdatavalid), 32'(k == 3 || k == 5));
            check($sformatf("t6_data_%0d", k), (k % 2 == 0) ? b_f_readdata : b_l_readdata,
                  32'hA000_0040 | 32'(k - 2));
         end else begin
            check($sformatf("t6_early_f_%0d", k), 32'(b_f_readdatavalid), 32'd0);
            check($sformatf("t6_early_l_%0d", k), 32'(b_l_readdatavalid), 32'd0);
         end
         tick;
      end
      b_f_read = 1'b0; b_l_read = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
